// File: rtl/clause_status_tracker.sv
// Clause status tracker: accumulates per-slice falsified-literal masks into a
// persistent literal-false register file and, once per pass, reports the
// lowest-indexed conflict clause and lowest-indexed unit clause.
module clause_status_tracker #(
   parameter int unsigned NUM_CLAUSES           = 64,
   parameter int unsigned NUM_CLAUSES_PER_CYCLE = 16,
   parameter int unsigned NUM_VARS_PER_CLAUSE   = 3,
   parameter int unsigned BITMASK_WIDTH         = NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE,
   parameter int unsigned NUM_SLICES            = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
   parameter int unsigned CLAUSE_IDX_BITS       = $clog2(NUM_CLAUSES)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       clear,
   input  logic                       bitmask_valid,
   input  logic [BITMASK_WIDTH-1:0]   bitmask_in,
   output logic                       bitmask_ready,
   output logic                       busy,
   output logic                       done,
   output logic                       conflict,
   output logic [CLAUSE_IDX_BITS-1:0] conflict_clause,
   output logic                       unit_found,
   output logic [CLAUSE_IDX_BITS-1:0] unit_clause
);

   localparam int unsigned SLICE_BITS = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam int unsigned LIT_BITS   = NUM_CLAUSES * NUM_VARS_PER_CLAUSE;
   localparam logic [SLICE_BITS-1:0] LAST_SLICE = SLICE_BITS'(NUM_SLICES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t                     state;
   logic [SLICE_BITS-1:0]      slice_cnt;
   logic [LIT_BITS-1:0]        lit_false;

   int unsigned                slice_base;
   logic [BITMASK_WIDTH-1:0]   new_lits;
   logic                       accept;
   logic                       conf_hit;
   logic                       unit_hit;
   logic [CLAUSE_IDX_BITS-1:0] conf_idx;
   logic [CLAUSE_IDX_BITS-1:0] unit_idx;

   // Merge the incoming beat with the stored slice and find the lowest
   // conflict / unit candidate among this slice's clauses.
   always_comb begin
      int unsigned pc;
      slice_base = int'(slice_cnt) * BITMASK_WIDTH;
      new_lits   = lit_false[slice_base +: BITMASK_WIDTH] | bitmask_in;
      accept     = bitmask_valid && bitmask_ready;
      conf_hit   = 1'b0;
      unit_hit   = 1'b0;
      conf_idx   = '0;
      unit_idx   = '0;
      pc         = 0;
      for (int unsigned j = 0; j < NUM_CLAUSES_PER_CYCLE; j++) begin
         pc = 0;
         for (int unsigned k = 0; k < NUM_VARS_PER_CLAUSE; k++) begin
            pc = pc + 32'(new_lits[j*NUM_VARS_PER_CLAUSE + k]);
         end
         if ((pc == NUM_VARS_PER_CLAUSE) && !conf_hit) begin
            conf_hit = 1'b1;
            conf_idx = CLAUSE_IDX_BITS'(int'(slice_cnt) * NUM_CLAUSES_PER_CYCLE + j);
         end
         if ((pc == NUM_VARS_PER_CLAUSE - 1) && !unit_hit) begin
            unit_hit = 1'b1;
            unit_idx = CLAUSE_IDX_BITS'(int'(slice_cnt) * NUM_CLAUSES_PER_CYCLE + j);
         end
      end
   end

   // Pass control FSM with registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         slice_cnt       <= '0;
         lit_false       <= '0;
         bitmask_ready   <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         conflict        <= 1'b0;
         conflict_clause <= '0;
         unit_found      <= 1'b0;
         unit_clause     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clear) begin
                  lit_false <= '0;
               end else if (start) begin
                  state           <= SCAN;
                  slice_cnt       <= '0;
                  bitmask_ready   <= 1'b1;
                  busy            <= 1'b1;
                  conflict        <= 1'b0;
                  conflict_clause <= '0;
                  unit_found      <= 1'b0;
                  unit_clause     <= '0;
               end
            end
            SCAN: begin
               if (accept) begin
                  lit_false[slice_base +: BITMASK_WIDTH] <= new_lits;
                  // Slices arrive in ascending order, so the first hit is the global minimum.
                  if (!conflict && conf_hit) begin
                     conflict        <= 1'b1;
                     conflict_clause <= conf_idx;
                  end
                  if (!unit_found && unit_hit) begin
                     unit_found  <= 1'b1;
                     unit_clause <= unit_idx;
                  end
                  if (slice_cnt == LAST_SLICE) begin
                     state         <= DONE;
                     slice_cnt     <= '0;
                     bitmask_ready <= 1'b0;
                     done          <= 1'b1;
                  end else begin
                     slice_cnt <= slice_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state         <= IDLE;
               bitmask_ready <= 1'b0;
               busy          <= 1'b0;
               done          <= 1'b0;
            end
         endcase
      end
   end

endmodule
